// File: rtl/ldpc_wb_sequencer.sv
// Wishbone-slave sequencer for the LDPC core: register file, job FSM with
// cycle counter and timeout, result capture and level interrupt.
module ldpc_wb_sequencer #(
    parameter int N_WORDS = 4,
    parameter int TIMEOUT = 1024,
    parameter int CW      = 16
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic                   wbs_cyc_i,
    input  logic                   wbs_stb_i,
    input  logic                   wbs_we_i,
    input  logic [3:0]             wbs_sel_i,
    input  logic [31:0]            wbs_adr_i,
    input  logic [31:0]            wbs_dat_i,
    output logic                   wbs_ack_o,
    output logic [31:0]            wbs_dat_o,
    output logic [32*N_WORDS-1:0]  core_din_o,
    output logic                   core_mode_o,
    output logic                   core_start_o,
    output logic                   core_abort_o,
    input  logic                   core_done_i,
    input  logic                   core_err_i,
    input  logic [32*N_WORDS-1:0]  core_dout_i,
    output logic                   irq_o
);

    typedef enum logic [2:0] {IDLE, START, WAIT, CAPTURE, ABORT} state_t;

    localparam logic [CW-1:0] LAST   = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

    state_t         state, state_nx;
    logic [5:0]     off;
    logic           req, wr, busy, wr_ctrl, wr_stat, launch;
    logic           irq_en, mode, flag_done, flag_timeout, err, err_hold;
    logic [CW-1:0]  cnt, cycles;
    logic [31:0]    din       [N_WORDS];
    logic [31:0]    dout      [N_WORDS];
    logic [31:0]    dout_hold [N_WORDS];
    logic [31:0]    rdata;
    logic           unused_adr;

    assign unused_adr = ^{wbs_adr_i[31:8], wbs_adr_i[1:0]};

    assign off     = wbs_adr_i[7:2];
    assign req     = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
    assign wr      = req & wbs_we_i;
    assign busy    = (state != IDLE);
    assign wr_ctrl = wr && (off == 6'h00) && wbs_sel_i[0];
    assign wr_stat = wr && (off == 6'h01) && wbs_sel_i[0];
    assign launch  = wr_ctrl && wbs_dat_i[0] && !busy;

    assign core_mode_o = mode;

    for (genvar g = 0; g < N_WORDS; g++) begin : g_din
        assign core_din_o[32*g +: 32] = din[g];
    end

    always_comb begin
        rdata = '0;
        case (off)
            6'h00:   rdata = {29'd0, mode, irq_en, 1'b0};
            6'h01:   rdata = {28'd0, err, flag_timeout, flag_done, busy};
            6'h02:   rdata = 32'(cycles);
            default: rdata = '0;
        endcase
        for (int i = 0; i < N_WORDS; i++) begin
            if (off == 6'(16 + i)) rdata = din[i];
            if (off == 6'(32 + i)) rdata = dout[i];
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx     = state;
        core_start_o = 1'b0;
        core_abort_o = 1'b0;
        case (state)
            IDLE:    if (launch) state_nx = START;
            START: begin
                core_start_o = 1'b1;
                state_nx     = WAIT;
            end
            // done takes priority over the timeout threshold
            WAIT: begin
                if (core_done_i)      state_nx = CAPTURE;
                else if (cnt == LAST) state_nx = ABORT;
            end
            CAPTURE: state_nx = IDLE;
            ABORT: begin
                core_abort_o = 1'b1;
                state_nx     = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbs_ack_o    <= 1'b0;
            wbs_dat_o    <= '0;
            irq_o        <= 1'b0;
            irq_en       <= 1'b0;
            mode         <= 1'b0;
            flag_done    <= 1'b0;
            flag_timeout <= 1'b0;
            err          <= 1'b0;
            err_hold     <= 1'b0;
            cnt          <= '0;
            cycles       <= '0;
            for (int i = 0; i < N_WORDS; i++) begin
                din[i]       <= '0;
                dout[i]      <= '0;
                dout_hold[i] <= '0;
            end
        end else begin
            wbs_ack_o <= req;
            wbs_dat_o <= req ? rdata : '0;
            irq_o     <= irq_en & (flag_done | flag_timeout);

            if (wr_ctrl) begin
                irq_en <= wbs_dat_i[1];
                if (!busy) mode <= wbs_dat_i[2];
            end

            // later assignments win: a flag being set beats a W1C in the same cycle
            if (wr_stat && wbs_dat_i[1]) flag_done    <= 1'b0;
            if (wr_stat && wbs_dat_i[2]) flag_timeout <= 1'b0;
            if (launch) begin
                flag_done    <= 1'b0;
                flag_timeout <= 1'b0;
            end
            if (state == CAPTURE) flag_done    <= 1'b1;
            if (state == ABORT)   flag_timeout <= 1'b1;

            if (wr && !busy) begin
                for (int i = 0; i < N_WORDS; i++) begin
                    if (off == 6'(16 + i)) begin
                        for (int b = 0; b < 4; b++) begin
                            if (wbs_sel_i[b]) din[i][8*b +: 8] <= wbs_dat_i[8*b +: 8];
                        end
                    end
                end
            end

            case (state)
                START: cnt <= '0;
                WAIT: begin
                    cnt <= cnt + CW'(1);
                    if (core_done_i) begin
                        err_hold <= core_err_i;
                        for (int i = 0; i < N_WORDS; i++) begin
                            dout_hold[i] <= core_dout_i[32*i +: 32];
                        end
                    end
                end
                CAPTURE: begin
                    err    <= err_hold;
                    cycles <= cnt;
                    for (int i = 0; i < N_WORDS; i++) begin
                        dout[i] <= dout_hold[i];
                    end
                end
                ABORT:   cycles <= TO_VAL;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ldpc_wb_sequencer.sv
// Directed bench for ldpc_wb_sequencer: register table plus hand-written
// job sequences (normal completion, timeout, threshold race, busy, reset).
module tb_ldpc_wb_sequencer;

    localparam int NW = 4;
    localparam int TO = 16;
    localparam int CW = 16;

    logic              clk, rst;
    logic              cyc, stb, we;
    logic [3:0]        sel;
    logic [31:0]       adr, dat_i;
    logic              ack;
    logic [31:0]       dat_o;
    logic [32*NW-1:0]  core_din;
    logic              core_mode, core_start, core_abort;
    logic              core_done, core_err;
    logic [32*NW-1:0]  core_dout;
    logic              irq;

    int n_checks = 0;
    int n_fail   = 0;
    int start_cnt = 0;
    int abort_cnt = 0;

    ldpc_wb_sequencer #(.N_WORDS(NW), .TIMEOUT(TO), .CW(CW)) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .wbs_cyc_i    (cyc),
        .wbs_stb_i    (stb),
        .wbs_we_i     (we),
        .wbs_sel_i    (sel),
        .wbs_adr_i    (adr),
        .wbs_dat_i    (dat_i),
        .wbs_ack_o    (ack),
        .wbs_dat_o    (dat_o),
        .core_din_o   (core_din),
        .core_mode_o  (core_mode),
        .core_start_o (core_start),
        .core_abort_o (core_abort),
        .core_done_i  (core_done),
        .core_err_i   (core_err),
        .core_dout_i  (core_dout),
        .irq_o        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (core_start) start_cnt++;
        if (core_abort) abort_cnt++;
    end

    typedef struct {
        logic        wr;
        logic [5:0]  a;
        logic [31:0] d;
        logic [3:0]  s;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[22];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wb(input logic w, input logic [5:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] r);
        int n;
        cyc = 1'b1; stb = 1'b1; we = w;
        adr = {24'h0, a, 2'b00}; dat_i = d; sel = s;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!ack && n < 8);
        n_checks++;
        if (!ack) begin
            n_fail++;
            $display("FAIL wb_ack adr=%0h: no ack within 8 cycles", a);
        end
        r = dat_o;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        wb(1'b1, a, d, s, r);
    endtask

    task automatic rd_chk(input string name, input logic [5:0] a, input logic [31:0] exp);
        logic [31:0] r;
        wb(1'b0, a, 32'h0, 4'hF, r);
        check(name, r, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int s0, a0;
        logic [31:0] r;

        vecs[0]  = '{1'b1, 6'h11, 32'h12345678, 4'hF, 32'h0};
        vecs[1]  = '{1'b1, 6'h11, 32'h0000AB00, 4'h2, 32'h0};
        vecs[2]  = '{1'b0, 6'h11, 32'h0, 4'hF, 32'h1234AB78};
        vecs[3]  = '{1'b0, 6'h3F, 32'h0, 4'hF, 32'h0};
        vecs[4]  = '{1'b1, 6'h3F, 32'hDEADBEEF, 4'hF, 32'h0};
        vecs[5]  = '{1'b0, 6'h3F, 32'h0, 4'hF, 32'h0};
        vecs[6]  = '{1'b0, 6'h15, 32'h0, 4'hF, 32'h0};
        vecs[7]  = '{1'b0, 6'h25, 32'h0, 4'hF, 32'h0};
        vecs[8]  = '{1'b0, 6'h00, 32'h0, 4'hF, 32'h0};
        vecs[9]  = '{1'b0, 6'h01, 32'h0, 4'hF, 32'h0};
        vecs[10] = '{1'b0, 6'h02, 32'h0, 4'hF, 32'h0};
        vecs[11] = '{1'b1, 6'h20, 32'hFFFFFFFF, 4'hF, 32'h0};
        vecs[12] = '{1'b0, 6'h20, 32'h0, 4'hF, 32'h0};
        vecs[13] = '{1'b1, 6'h10, 32'h11111111, 4'hF, 32'h0};
        vecs[14] = '{1'b1, 6'h11, 32'h22222222, 4'hF, 32'h0};
        vecs[15] = '{1'b1, 6'h12, 32'h33333333, 4'hF, 32'h0};
        vecs[16] = '{1'b1, 6'h13, 32'h44444444, 4'hF, 32'h0};
        vecs[17] = '{1'b1, 6'h00, 32'h00000006, 4'h1, 32'h0};
        vecs[18] = '{1'b0, 6'h00, 32'h0, 4'hF, 32'h00000006};
        vecs[19] = '{1'b0, 6'h10, 32'h0, 4'hF, 32'h11111111};
        vecs[20] = '{1'b0, 6'h13, 32'h0, 4'hF, 32'h44444444};
        vecs[21] = '{1'b0, 6'h12, 32'h0, 4'hF, 32'h33333333};

        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
        adr = '0; dat_i = '0; core_done = 1'b0; core_err = 1'b0; core_dout = '0;
        tick(3);
        rst = 1'b0;
        tick(1);
        check("reset_ack", ack, 1'b0);
        check("reset_irq", irq, 1'b0);
        check("reset_start", core_start, 1'b0);
        check("reset_abort", core_abort, 1'b0);
        check("reset_din", core_din, '0);
        check("reset_mode", core_mode, 1'b0);

        // register-access table
        for (int i = 0; i < 22; i++) begin
            wb(vecs[i].wr, vecs[i].a, vecs[i].d, vecs[i].s, r);
            if (!vecs[i].wr) check($sformatf("vec%0d_adr%0h", i, vecs[i].a), r, vecs[i].exp);
        end
        check("din_vector", core_din, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111});
        check("mode_set", core_mode, 1'b1);

        // normal job: done 5 cycles after the start pulse
        s0 = start_cnt;
        wr(6'h00, 32'h7, 4'h1);
        check("job1_start_pulse_now", core_start, 1'b1);
        tick(5);
        core_done = 1'b1; core_err = 1'b0;
        core_dout = {32'h0000000D, 32'h0000000C, 32'h0000000B, 32'h0000000A};
        tick(1);
        core_done = 1'b0; core_err = 1'b1; core_dout = '1;
        tick(3);
        check("job1_start_count", start_cnt - s0, 1);
        check("job1_irq", irq, 1'b1);
        rd_chk("job1_status", 6'h01, 32'h2);
        rd_chk("job1_cycles", 6'h02, 32'd5);
        for (int i = 0; i < NW; i++) rd_chk($sformatf("job1_dout%0d", i), 6'(32 + i), 32'hA + i);

        // timeout job: core never answers
        a0 = abort_cnt;
        wr(6'h00, 32'h7, 4'h1);
        tick(25);
        check("to_abort_count", abort_cnt - a0, 1);
        rd_chk("to_status", 6'h01, 32'h4);
        rd_chk("to_cycles", 6'h02, 32'd16);
        rd_chk("to_dout0", 6'h20, 32'hA);
        rd_chk("to_dout3", 6'h23, 32'hD);
        check("to_irq", irq, 1'b1);

        // done on the threshold cycle beats the timeout
        a0 = abort_cnt;
        wr(6'h00, 32'h7, 4'h1);
        tick(16);
        core_done = 1'b1; core_err = 1'b0;
        core_dout = {32'h5555_0004, 32'h5555_0003, 32'h5555_0002, 32'h5555_0001};
        tick(1);
        core_done = 1'b0; core_dout = '0;
        tick(4);
        check("thr_no_abort", abort_cnt - a0, 0);
        rd_chk("thr_status", 6'h01, 32'h2);
        rd_chk("thr_cycles", 6'h02, 32'd16);
        rd_chk("thr_dout0", 6'h20, 32'h5555_0001);

        // writes while busy: DIN, MODE and START are dropped, IRQ_EN still lands
        s0 = start_cnt;
        wr(6'h00, 32'h7, 4'h1);
        wr(6'h10, 32'hFFFFFFFF, 4'hF);
        wr(6'h00, 32'h3, 4'h1);
        rd_chk("busy_din0", 6'h10, 32'h11111111);
        check("busy_mode", core_mode, 1'b1);
        tick(25);
        check("busy_start_count", start_cnt - s0, 1);
        rd_chk("busy_status", 6'h01, 32'h4);
        rd_chk("busy_ctrl", 6'h00, 32'h6);

        // done outside WAIT is ignored
        core_done = 1'b1;
        tick(1);
        core_done = 1'b0;
        tick(2);
        rd_chk("idle_done_ignored", 6'h01, 32'h4);

        // W1C of TIMEOUT drops the flag and then the interrupt
        wr(6'h01, 32'h4, 4'h1);
        rd_chk("w1c_status", 6'h01, 32'h0);
        tick(2);
        check("w1c_irq", irq, 1'b0);

        // reset in the middle of WAIT
        wr(6'h00, 32'h7, 4'h1);
        tick(3);
        a0 = abort_cnt;
        rst = 1'b1;
        tick(1);
        check("rst_ack", ack, 1'b0);
        check("rst_irq", irq, 1'b0);
        check("rst_mode", core_mode, 1'b0);
        check("rst_din", core_din, '0);
        check("rst_start", core_start, 1'b0);
        check("rst_abort_out", core_abort, 1'b0);
        rst = 1'b0;
        tick(2);
        check("rst_no_abort", abort_cnt - a0, 0);
        rd_chk("rst_status", 6'h01, 32'h0);
        rd_chk("rst_cycles", 6'h02, 32'h0);
        rd_chk("rst_dout0", 6'h20, 32'h0);
        rd_chk("rst_ctrl", 6'h00, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
